// File: rtl/storage_wb_initiator_if.sv
// rtl/storage_wb_initiator_if.sv - Wishbone bus between the block initiator and the two-strobe storage bridge
interface storage_wb_initiator_if;
  logic        wb_cyc_o;
  logic        wb_we_o;
  logic [1:0]  wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [1:0]  wb_ack_i;
  logic [31:0] wb_rw_dat_i;
  logic [31:0] wb_ro_dat_i;

  modport master (
    output wb_cyc_o, wb_we_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_rw_dat_i, wb_ro_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_we_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_rw_dat_i, wb_ro_dat_i
  );
endinterface

// File: rtl/storage_wb_initiator.sv
// rtl/storage_wb_initiator.sv - block FILL/COPY/CHECKSUM engine issuing single-word classic Wishbone transfers
// CHECKSUM (op 2) and its accumulator exist only with STORAGE_INIT_CHECKSUM_EN defined.
module storage_wb_initiator #(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] RO_BLOCK       = 8'h20
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [31:0]           cmd_src_i,
  input  logic [31:0]           cmd_dst_i,
  input  logic [9:0]            cmd_len_i,
  input  logic [31:0]           cmd_pattern_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           result_o,
  storage_wb_initiator_if.master wb
);

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_CSUM = 2'd2;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
`ifdef STORAGE_INIT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, GAP, FIN} state_t;

  state_t      state, state_nx;
  logic        armed, err_q, last_rd;
  logic [1:0]  op_q;
  logic [31:0] src_q, dst_q, wdata_q;
  logic [9:0]  len_q, cnt_q;
  logic [7:0]  tmo_q;
`ifdef STORAGE_INIT_CHECKSUM_EN
  logic [31:0] acc_q;
`endif

  logic        accept, reject, writes, reads, strobe, cur_ro, ack_hit, tmo_hit;
  logic [31:0] cur_adr, rd_data;

  // Each port only decodes part of the word index, so its window is 512 (R/W) or 256 (RO) words.
  function automatic logic win_over(input logic [31:0] adr, input logic [9:0] len);
    if (adr[23:16] == RO_BLOCK)
      return ({3'b0, adr[9:2]} + {1'b0, len}) > 11'd256;
    return ({2'b0, adr[10:2]} + {1'b0, len}) > 11'd512;
  endfunction

  assign cmd_ready_o = armed && (state == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == FIN);
  assign err_o       = err_q;
`ifdef STORAGE_INIT_CHECKSUM_EN
  assign result_o    = (op_q == OP_CSUM) ? acc_q : {22'b0, cnt_q};
`else
  assign result_o    = {22'b0, cnt_q};
`endif

  assign writes  = (op_q == OP_FILL) || (op_q == OP_COPY);
  assign reads   = (op_q == OP_COPY) || (op_q == OP_CSUM);
  assign reject  = (len_q == 10'd0) || (len_q > 10'd512) ||
                   (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00) ||
                   (op_q == 2'd3) || ((op_q == OP_CSUM) && !CSUM_EN) ||
                   (writes && ((dst_q[23:16] == RO_BLOCK) || win_over(dst_q, len_q))) ||
                   (reads && win_over(src_q, len_q));

  assign strobe  = (state == RD) || (state == WR);
  assign cur_adr = (state == WR) ? dst_q : src_q;
  assign cur_ro  = (cur_adr[23:16] == RO_BLOCK);
  assign ack_hit = cur_ro ? wb.wb_ack_i[1] : wb.wb_ack_i[0];
  assign rd_data = cur_ro ? wb.wb_ro_dat_i : wb.wb_rw_dat_i;
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_nx    = state;
    wb.wb_cyc_o = strobe || (state == GAP);
    wb.wb_stb_o = 2'b00;
    wb.wb_adr_o = 32'h0;
    wb.wb_we_o  = 1'b0;
    wb.wb_dat_o = 32'h0;
    wb.wb_sel_o = 4'h0;
    if (strobe) begin
      wb.wb_stb_o = cur_ro ? 2'b10 : 2'b01;
      wb.wb_adr_o = cur_adr;
    end
    if (state == WR) begin
      wb.wb_we_o  = 1'b1;
      wb.wb_dat_o = wdata_q;
      wb.wb_sel_o = 4'hF;
    end
    case (state)
      IDLE:    if (accept) state_nx = CHECK;
      CHECK:   state_nx = reject ? FIN : ((op_q == OP_FILL) ? WR : RD);
      RD, WR: begin
        if (ack_hit)      state_nx = GAP;
        else if (tmo_hit) state_nx = FIN;
      end
      // A COPY read is always followed by the write of the same word.
      GAP: begin
        if (last_rd && (op_q == OP_COPY)) state_nx = WR;
        else if (cnt_q == len_q)          state_nx = FIN;
        else if (op_q == OP_FILL)         state_nx = WR;
        else                              state_nx = RD;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      armed   <= 1'b0;
      err_q   <= 1'b0;
      last_rd <= 1'b0;
      op_q    <= 2'd0;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      wdata_q <= 32'h0;
      len_q   <= 10'd0;
      cnt_q   <= 10'd0;
      tmo_q   <= 8'd0;
`ifdef STORAGE_INIT_CHECKSUM_EN
      acc_q   <= 32'h0;
`endif
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          op_q    <= cmd_op_i;
          src_q   <= cmd_src_i;
          dst_q   <= cmd_dst_i;
          len_q   <= cmd_len_i;
          wdata_q <= cmd_pattern_i;
          err_q   <= 1'b0;
          cnt_q   <= 10'd0;
`ifdef STORAGE_INIT_CHECKSUM_EN
          acc_q   <= 32'h0;
`endif
        end
        CHECK: begin
          tmo_q   <= 8'd0;
          last_rd <= 1'b0;
          if (reject) err_q <= 1'b1;
        end
        RD, WR: begin
          if (ack_hit) begin
            tmo_q   <= 8'd0;
            last_rd <= (state == RD);
            if (state == RD) begin
              src_q <= src_q + 32'd4;
              if (op_q == OP_COPY) wdata_q <= rd_data;
              else                 cnt_q   <= cnt_q + 10'd1;
`ifdef STORAGE_INIT_CHECKSUM_EN
              if (op_q == OP_CSUM) acc_q <= acc_q + rd_data;
`endif
            end else begin
              dst_q <= dst_q + 32'd4;
              cnt_q <= cnt_q + 10'd1;
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_wb_initiator.sv
// tb/tb_storage_wb_initiator.sv - scoreboard bench for storage_wb_initiator with a bridge model
module tb_storage_wb_initiator;
  localparam int TMO = 8;
`ifdef STORAGE_INIT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_src = 32'h0, cmd_dst = 32'h0, cmd_pat = 32'h0;
  logic [9:0]  cmd_len = 10'd0;
  logic        busy, done, err;
  logic [31:0] result;

  always #5 clk = ~clk;

  storage_wb_initiator_if bus ();

  storage_wb_initiator #(.TIMEOUT_CYCLES(TMO), .RO_BLOCK(8'h20)) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_src_i     (cmd_src),
    .cmd_dst_i     (cmd_dst),
    .cmd_len_i     (cmd_len),
    .cmd_pattern_i (cmd_pat),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .result_o      (result),
    .wb            (bus)
  );

  typedef struct { logic err; logic [31:0] result; int lat; } resp_t;
  typedef struct { logic we; logic port; logic [31:0] adr; logic [31:0] dat; } xfer_t;

  resp_t       exp_q[$];
  xfer_t       xq[$];
  int          checks = 0, errors = 0;
  int          cyc_cnt = 0, acc_cyc = 0, stb_run = 0;
  logic [31:0] ro_mem [256];
  logic        stall_en = 1'b0;
  logic [31:0] stall_adr = 32'h0;
  logic        noise = 1'b0;
  logic        ack_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic is_ro(input logic [31:0] a);
    return ((a >> 16) & 32'hFF) == 32'h20;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return is_ro(a) ? ro_mem[(a / 4) % 256] : (a ^ 32'hC3C3_0F0F);
  endfunction

  function automatic bit overflow(input logic [31:0] a, input int len);
    int off;
    if (is_ro(a)) begin
      off = int'((a / 4) % 256);
      return off + len > 256;
    end
    off = int'((a / 4) % 512);
    return off + len > 512;
  endfunction

  function automatic bit legal(input int op, input logic [31:0] src, input logic [31:0] dst, input int len);
    if (len < 1 || len > 512) return 1'b0;
    if (src % 4 != 0 || dst % 4 != 0) return 1'b0;
    if (op == 3 || (op == 2 && !CSUM_EN)) return 1'b0;
    if (op != 2 && (is_ro(dst) || overflow(dst, len))) return 1'b0;
    if (op != 0 && overflow(src, len)) return 1'b0;
    return 1'b1;
  endfunction

  // Bridge model: writes ack in the first strobe cycle, reads in the second; stray ack noise on the idle bit.
  assign bus.wb_rw_dat_i = bus.wb_adr_o ^ 32'hC3C3_0F0F;
  assign bus.wb_ro_dat_i = ro_mem[bus.wb_adr_o[9:2]];

  always_comb begin
    ack_ok = bus.wb_we_o ? !(stall_en && bus.wb_adr_o == stall_adr) : (stb_run >= 1);
    case (bus.wb_stb_o)
      2'b01:   bus.wb_ack_i = {noise, ack_ok};
      2'b10:   bus.wb_ack_i = {ack_ok, noise};
      default: bus.wb_ack_i = {noise, noise};
    endcase
  end

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    stb_run <= (bus.wb_stb_o != 2'b00) ? stb_run + 1 : 0;
  end

  xfer_t mon_x;
  always @(negedge clk) begin
    noise <= 1'($urandom_range(0, 1));
    if (bus.wb_stb_o == 2'b11) begin
      checks++; errors++;
      $display("FAIL stb_onehot: got stb=%b expected a single bit", bus.wb_stb_o);
    end else if (rst_n && bus.wb_stb_o != 2'b00 && bus.wb_ack_i[bus.wb_stb_o[1]]) begin
      if (xq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_xfer: got adr=0x%0h we=%b expected no transfer", bus.wb_adr_o, bus.wb_we_o);
      end else begin
        mon_x = xq.pop_front();
        chk("xfer_hdr", {bus.wb_cyc_o, bus.wb_we_o, bus.wb_stb_o[1], bus.wb_adr_o},
                        {1'b1, mon_x.we, mon_x.port, mon_x.adr});
        if (mon_x.we) chk("xfer_wdata", {bus.wb_sel_o, bus.wb_dat_o}, {4'hF, mon_x.dat});
        else          chk("xfer_rsel", {60'h0, bus.wb_sel_o}, 64'h0);
      end
    end
  end

  resp_t mon_r;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no command outstanding");
      end else begin
        mon_r = exp_q.pop_front();
        chk("done_err", {63'h0, err}, {63'h0, mon_r.err});
        chk("done_result", {32'h0, result}, {32'h0, mon_r.result});
        if (mon_r.lat >= 0) chk("done_latency", 64'(cyc_cnt - acc_cyc), 64'(mon_r.lat));
        chk("xfers_left", 64'(xq.size()), 64'h0);
        xq.delete();
      end
    end
  end

  task automatic start_cmd(input int op, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input logic [31:0] pat, input int stall_idx);
    resp_t       r;
    int          n;
    logic [31:0] sum, a_s, a_d;
    bit          ok;
    ok       = legal(op, src, dst, len);
    r.err    = !ok;
    r.result = 32'h0;
    r.lat    = 2;
    if (ok) begin
      n   = (stall_idx >= 0) ? stall_idx : len;
      sum = 32'h0;
      for (int i = 0; i < n; i++) begin
        a_s = src + 32'(4 * i);
        a_d = dst + 32'(4 * i);
        if (op != 0) xq.push_back('{we: 1'b0, port: is_ro(a_s), adr: a_s, dat: 32'h0});
        if (op == 0) xq.push_back('{we: 1'b1, port: is_ro(a_d), adr: a_d, dat: pat});
        if (op == 1) xq.push_back('{we: 1'b1, port: is_ro(a_d), adr: a_d, dat: mem_word(a_s)});
        if (op == 2) sum = sum + mem_word(a_s);
      end
      r.result = (op == 2) ? sum : 32'(n);
      r.lat    = (op == 0) ? 2 + 2 * n : (op == 2) ? 2 + 3 * len : -1;
      if (stall_idx >= 0) begin
        r.err     = 1'b1;
        r.lat     = 2 + 2 * n + TMO;
        stall_en  = 1'b1;
        stall_adr = dst + 32'(4 * stall_idx);
      end
    end
    exp_q.push_back(r);
    @(negedge clk);
    cmd_op = 2'(op); cmd_src = src; cmd_dst = dst; cmd_len = 10'(len); cmd_pat = pat;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got cmd_ready_o=0 expected 1 within 50 cycles");
      exp_q.delete(); xq.delete();
      cmd_valid = 1'b0;
    end else begin
      acc_cyc = cyc_cnt;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_o expected one within 3000 cycles");
      exp_q.delete(); xq.delete();
    end
    stall_en = 1'b0;
  endtask

  task automatic run(input int op, input logic [31:0] src, input logic [31:0] dst,
                     input int len, input logic [31:0] pat, input int stall_idx);
    start_cmd(op, src, dst, len, pat, stall_idx);
    wait_done();
  endtask

  logic [31:0] r_src, r_dst;
  logic [7:0]  r_blk;
  int          r_len;

  initial begin
    for (int i = 0; i < 256; i++) ro_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_status", {60'h0, cmd_ready, busy, done, err}, 64'h0);
    chk("rst_bus", {55'h0, bus.wb_cyc_o, bus.wb_we_o, bus.wb_stb_o, bus.wb_sel_o}, 64'h0);
    chk("rst_result", {32'h0, result}, 64'h0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {63'h0, cmd_ready}, 64'h0);
    @(posedge clk);
    #1 chk("ready_after_edge", {63'h0, cmd_ready}, 64'h1);

    run(0, 32'h0000_0000, 32'h0000_0000, 4, 32'hA5A5_A5A5, -1);
    run(1, 32'h0020_0000, 32'h0010_0010, 2, 32'h0, -1);
    run(0, 32'h0000_0000, 32'h0020_0000, 1, 32'h1111_2222, -1);
    run(0, 32'h0000_0000, 32'h0000_0000, 0, 32'h1111_2222, -1);
    run(0, 32'h0000_0000, 32'h0000_07FC, 2, 32'h1111_2222, -1);
    run(1, 32'h0000_0002, 32'h0000_0000, 1, 32'h0, -1);
    run(3, 32'h0020_0000, 32'h0000_0000, 1, 32'h0, -1);
    run(0, 32'h0000_0000, 32'h0000_0000, 4, 32'h5A5A_0001, 2);
    ro_mem[0] = 32'h1; ro_mem[1] = 32'h2; ro_mem[2] = 32'hFFFF_FFFF;
    run(2, 32'h0020_0000, 32'h0000_0000, 3, 32'h0, -1);
    run(0, 32'h0000_0000, 32'h0000_07F8, 2, 32'hDEAD_BEEF, -1);

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 7))
        0:       r_blk = 8'h20;
        1, 2:    r_blk = 8'h10;
        default: r_blk = 8'h00;
      endcase
      r_dst = {8'h00, r_blk, 16'h0} +
              32'(4 * ($urandom_range(0, 1) ? $urandom_range(0, 511) : $urandom_range(505, 511)));
      if ($urandom_range(0, 9) == 0) r_dst = r_dst + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) r_src = 32'(4 * $urandom_range(0, 511));
      else r_src = 32'h0020_0000 +
                   32'(4 * ($urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(250, 255)));
      if ($urandom_range(0, 9) == 0) r_src = r_src + 32'($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0:       r_len = 0;
        1:       r_len = 513 + int'($urandom_range(0, 100));
        default: r_len = int'($urandom_range(1, 6));
      endcase
      run(int'($urandom_range(0, 3)), r_src, r_dst, r_len, $urandom, -1);
    end

    start_cmd(1, 32'h0020_0000, 32'h0010_0000, 4, 32'h0, -1);
    repeat (4) @(negedge clk);
    chk("busy_mid_copy", {63'h0, busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bus", {55'h0, bus.wb_cyc_o, bus.wb_we_o, bus.wb_stb_o, bus.wb_sel_o}, 64'h0);
    chk("async_rst_status", {60'h0, cmd_ready, busy, done, err}, 64'h0);
    chk("async_rst_result", {32'h0, result}, 64'h0);
    exp_q.delete(); xq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge2", {63'h0, cmd_ready}, 64'h0);
    @(posedge clk);
    #1 chk("ready_after_edge2", {63'h0, cmd_ready}, 64'h1);
    run(0, 32'h0000_0000, 32'h0010_0100, 3, 32'h0BAD_F00D, -1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
